// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_pkg
// Purpose : Shared types for the sequential signed/unsigned divider.
//           - state_t : FSM encoding IDLE / RUN / FIX (2 bits)
//           - cnt_width(): iteration counter width, $clog2(N+1)
// Revision: 1.0  initial release
// ============================================================================
package div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_div_sign_if.sv
`default_nettype none
// ============================================================================
// Module  : seq_div_sign_if
// Purpose : Request/result bundle of the sequential divider.
//   master : drives start, A (dividend), B (divisor), sn (signed mode)
//            receives busy, done, quot, rem, div_by_zero
//   slave  : the divider side of the same signals
// Revision: 1.0  initial release
// ============================================================================
interface seq_div_sign_if #(
   parameter int N = 32,
   parameter int M = 11
);
   logic         start;
   logic [N-1:0] A;
   logic [M-1:0] B;
   logic         sn;
   logic         busy;
   logic         done;
   logic [N-1:0] quot;
   logic [M-1:0] rem;
   logic         div_by_zero;

   modport master (
      output start, A, B, sn,
      input  busy, done, quot, rem, div_by_zero
   );

   modport slave (
      input  start, A, B, sn,
      output busy, done, quot, rem, div_by_zero
   );
endinterface
`default_nettype wire

// File: rtl/div_core_usign.sv
`default_nettype none
// ============================================================================
// Module  : div_core_usign
// Purpose : Unsigned radix-2 restoring division datapath.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture a_mag into the quotient register, clear remainder
//   step     : perform one shift / trial-subtract iteration
//   a_mag    : dividend magnitude (N bits)
//   b_mag    : divisor magnitude (M bits), must be stable during steps
//   q_mag    : quotient magnitude
//   r_mag    : remainder magnitude
// Revision: 1.0  initial release
// ============================================================================
module div_core_usign #(
   parameter int N = 32,
   parameter int M = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic [N-1:0] a_mag,
   input  logic [M-1:0] b_mag,
   output logic [N-1:0] q_mag,
   output logic [M-1:0] r_mag
);

   // The quotient register starts out holding the dividend; its MSB feeds
   // the remainder each step while quotient bits fill in from the LSB.
   logic [N-1:0] q_q, q_d;
   logic [M-1:0] r_q, r_d;
   logic [M:0]   r_shift;   // M+1 bits: pre-subtract partial remainder
   logic         r_ge;
   logic [M-1:0] r_sub;

   always_comb begin
      r_shift = {r_q, q_q[N-1]};
      r_ge    = (r_shift >= {1'b0, b_mag});
      // When r_ge holds the difference is below b_mag, so M bits suffice.
      r_sub   = r_shift[M-1:0] - b_mag;
      q_d     = q_q;
      r_d     = r_q;
      if (load) begin
         q_d = a_mag;
         r_d = '0;
      end else if (step) begin
         if (r_ge) begin
            r_d = r_sub;
            q_d = {q_q[N-2:0], 1'b1};
         end else begin
            r_d = r_shift[M-1:0];
            q_d = {q_q[N-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
         r_q <= '0;
      end else begin
         q_q <= q_d;
         r_q <= r_d;
      end
   end

   assign q_mag = q_q;
   assign r_mag = r_q;

endmodule
`default_nettype wire

// File: rtl/seq_div_sign.sv
`default_nettype none
// ============================================================================
// Module  : seq_div_sign
// Purpose : Iterative signed/unsigned divider, N-bit dividend / M-bit divisor.
//           Magnitudes are divided by div_core_usign, then one FIX cycle
//           applies C-style sign correction (truncate toward zero, remainder
//           follows the dividend). done pulses N+1 edges after start.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_div_sign_if.slave (start/A/B/sn in; busy/done/quot/rem/
//              div_by_zero out)
// Revision: 1.0  initial release
// ============================================================================
module seq_div_sign
   import div_pkg::*;
#(
   parameter int N = 32,
   parameter int M = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   seq_div_sign_if.slave        bus
);

   localparam int CW = cnt_width(N);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           sa_q, sa_d;       // dividend negative
   logic           sb_q, sb_d;       // divisor negative
   logic           zero_q, zero_d;   // captured divisor was zero
   logic [M-1:0]   b_mag_q, b_mag_d;
   logic [M-1:0]   a_lo_q, a_lo_d;   // raw low dividend bits for B==0 result
   logic [N-1:0]   quot_q, quot_d;
   logic [M-1:0]   rem_q, rem_d;
   logic           dbz_q, dbz_d;
   logic           done_q, done_d;

   logic           a_neg, b_neg;
   logic [N-1:0]   a_mag;
   logic           load, step;
   logic [N-1:0]   q_mag;
   logic [M-1:0]   r_mag;

   // Operand magnitudes from the live bus; only used on the capture edge.
   always_comb begin
      a_neg = bus.sn & bus.A[N-1];
      b_neg = bus.sn & bus.B[M-1];
      a_mag = a_neg ? ('0 - bus.A) : bus.A;
   end

   assign load = (state_q == ST_IDLE) && bus.start;
   assign step = (state_q == ST_RUN);

   div_core_usign #(.N(N), .M(M)) u_core (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .step  (step),
      .a_mag (a_mag),
      .b_mag (b_mag_q),
      .q_mag (q_mag),
      .r_mag (r_mag)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      zero_d  = zero_q;
      b_mag_d = b_mag_q;
      a_lo_d  = a_lo_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               sa_d    = a_neg;
               sb_d    = b_neg;
               zero_d  = (bus.B == '0);
               b_mag_d = b_neg ? ('0 - bus.B) : bus.B;
               a_lo_d  = bus.A[M-1:0];
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            if (zero_q) begin
               quot_d = '1;
               rem_d  = a_lo_q;
            end else begin
               quot_d = (sa_q ^ sb_q) ? ('0 - q_mag) : q_mag;
               rem_d  = sa_q ? ('0 - r_mag) : r_mag;
            end
            dbz_d   = zero_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         zero_q  <= 1'b0;
         b_mag_q <= '0;
         a_lo_q  <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         zero_q  <= zero_d;
         b_mag_q <= b_mag_d;
         a_lo_q  <= a_lo_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.done        = done_q;
   assign bus.quot        = quot_q;
   assign bus.rem         = rem_q;
   assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_div_sign.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_div_sign
// Purpose : Directed self-checking bench for seq_div_sign (N=32, M=11).
// Revision: 1.0  initial release
// ============================================================================
module tb_seq_div_sign;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   seq_div_sign_if #(.N(32), .M(11)) bus ();

   seq_div_sign #(.N(32), .M(11)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        sn;
      logic [31:0] a;
      logic [10:0] b;
      logic [31:0] q;
      logic [10:0] r;
      logic        z;
   } vec_t;

   vec_t vecs [12] = '{
      '{1'b0, 32'd100,       11'd7,     32'd14,        11'd2,     1'b0},
      '{1'b1, 32'hFFFFFF9C,  11'd7,     32'hFFFFFFF2,  11'h7FE,   1'b0},
      '{1'b1, 32'd100,       11'h7F9,   32'hFFFFFFF2,  11'd2,     1'b0},
      '{1'b1, 32'h80000000,  11'h7FF,   32'h80000000,  11'd0,     1'b0},
      '{1'b0, 32'hFFFFFFFF,  11'h7FF,   32'h00200400,  11'h3FF,   1'b0},
      '{1'b0, 32'h00000123,  11'd0,     32'hFFFFFFFF,  11'h123,   1'b1},
      '{1'b1, 32'hFFFFFF9C,  11'd0,     32'hFFFFFFFF,  11'h79C,   1'b1},
      '{1'b1, 32'hFFFFFFF9,  11'h7FE,   32'd3,         11'h7FF,   1'b0},
      '{1'b1, 32'd7,         11'h7FE,   32'hFFFFFFFD,  11'd1,     1'b0},
      '{1'b1, 32'h80000000,  11'h400,   32'h00200000,  11'd0,     1'b0},
      '{1'b0, 32'hFFFFFFFF,  11'h400,   32'h003FFFFF,  11'h3FF,   1'b0},
      '{1'b0, 32'd0,         11'd5,     32'd0,         11'd0,     1'b0}
   };

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Drive a request so that the next rising edge samples it (E0).
   task automatic launch(input logic sn, input logic [31:0] a, input logic [10:0] b);
      bus.sn    = sn;
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Count edges until done is seen; bounded so a stuck DUT still ends.
   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!bus.done && lat < 60);
   endtask

   task automatic chk_result(input string tag, input logic [31:0] q,
                             input logic [10:0] r, input logic z);
      chk({tag, "_quot"}, bus.quot, q);
      chk({tag, "_rem"},  32'(bus.rem), 32'(r));
      chk({tag, "_dbz"},  32'(bus.div_by_zero), 32'(z));
   endtask

   initial begin
      int lat;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.sn    = 1'b0;
      #2;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk_result("rst", 32'd0, 11'd0, 1'b0);
      #10 rst = 1'b0;
      @(posedge clk); #1;

      // Directed vector table
      foreach (vecs[i]) begin
         launch(vecs[i].sn, vecs[i].a, vecs[i].b);
         chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd1);
         bus.A = 32'h5A5A5A5A;   // operands may change after capture
         bus.B = 11'h555;
         bus.sn = ~vecs[i].sn;
         wait_done(lat);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'd33);
         chk_result($sformatf("v%0d", i), vecs[i].q, vecs[i].r, vecs[i].z);
         chk($sformatf("v%0d_busy_done", i), 32'(bus.busy), 32'd0);
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
         chk($sformatf("v%0d_hold", i), bus.quot, vecs[i].q);
      end

      // start while busy is ignored
      launch(1'b0, 32'd100, 11'd7);
      repeat (9) @(posedge clk);
      #1;
      bus.A = 32'd5; bus.B = 11'd3; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(lat);
      chk("ign_lat", 32'(10 + lat), 32'd33);
      chk_result("ign", 32'd14, 11'd2, 1'b0);

      // back-to-back start in the done cycle
      launch(1'b1, 32'hFFFFFF9C, 11'd7);
      wait_done(lat);
      chk("b2b_lat", 32'(lat), 32'd33);
      chk_result("b2b", 32'hFFFFFFF2, 11'h7FE, 1'b0);

      // load nonzero outputs, then reset mid-operation
      launch(1'b0, 32'h00000123, 11'd0);
      wait_done(lat);
      chk_result("pre_rst", 32'hFFFFFFFF, 11'h123, 1'b1);
      launch(1'b0, 32'd100, 11'd7);
      repeat (14) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk_result("arst", 32'd0, 11'd0, 1'b0);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_done", 32'(bus.done), 32'd0);
      launch(1'b0, 32'd100, 11'd7);
      wait_done(lat);
      chk("fresh_lat", 32'(lat), 32'd33);
      chk_result("fresh", 32'd14, 11'd2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
